// File: rtl/l1_mem_responder_pkg.sv
// Shared types and constants for the L1 memory-side responder.
// State encoding, beat size and latency counter width.
package l1_mem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP,
    DRAIN
  } resp_state_e;

  localparam int BEAT_BYTES = 8;
  localparam int CNT_W      = 8;

endpackage

// File: rtl/mem_resp_sram.sv
// Byte-addressed backing store with one 64-bit little-endian port.
// Bytes are stored XORed with the init pattern so zeroed storage reads as the pattern.
module mem_resp_sram
  import l1_mem_responder_pkg::*;
#(
  parameter int MEM_BYTES    = 1048576,
  parameter int INIT_PATTERN = 1,
  localparam int AW          = $clog2(MEM_BYTES)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [63:0]   wdata,
  output logic [63:0]   rdata
);

  logic [7:0] mem [MEM_BYTES];

  function automatic logic [7:0] pat(input logic [AW-1:0] a);
    return (INIT_PATTERN != 0) ? 8'(a) : 8'h00;
  endfunction

  // Assemble the beat little-endian, removing the pattern overlay.
  always_comb begin
    rdata = '0;
    for (int k = 0; k < BEAT_BYTES; k++) begin
      rdata[8*k +: 8] = mem[addr + AW'(k)] ^ pat(addr + AW'(k));
    end
  end

  // Commit all eight bytes of a beat in one edge.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int k = 0; k < BEAT_BYTES; k++) begin
        mem[addr + AW'(k)] <= wdata[8*k +: 8] ^ pat(addr + AW'(k));
      end
    end
  end

endmodule

// File: rtl/l1_mem_responder.sv
// Memory-side responder for the L1 miss/writeback port.
// One request at a time, fixed latency, response echoes the request ID.
module l1_mem_responder
  import l1_mem_responder_pkg::*;
#(
  parameter int DATA_WIDTH   = 64,
  parameter int ADDR_WIDTH   = 64,
  parameter int ID_WIDTH     = 4,
  parameter int MEM_BYTES    = 1048576,
  parameter int LATENCY      = 5,
  parameter int INIT_PATTERN = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [ID_WIDTH-1:0]   mem_id,
  input  logic                  mem_request,
  output logic [DATA_WIDTH-1:0] mem_read_data,
  output logic                  mem_ready,
  output logic                  mem_error,
  output logic [ID_WIDTH-1:0]   mem_resp_id,
  output logic                  busy
);

  localparam int AW = $clog2(MEM_BYTES);

  resp_state_e           state;
  logic [CNT_W-1:0]      cnt;
  logic [ADDR_WIDTH-1:0] cap_addr;
  logic [DATA_WIDTH-1:0] cap_wdata;
  logic                  cap_rd;
  logic                  cap_wr;
  logic [ID_WIDTH-1:0]   cap_id;
  logic                  err;
  logic                  fire;
  logic [63:0]           sram_rdata;

  // Classify the captured request.
  always_comb begin
    err = (cap_addr >= ADDR_WIDTH'(MEM_BYTES))
       || (cap_addr[2:0] != 3'b000)
       || (cap_rd == cap_wr);
  end

  // Edge that enters RESP: writes commit, reads sample here.
  always_comb begin
    fire = (state == WAIT) && (cnt == '0);
  end

  mem_resp_sram #(
    .MEM_BYTES   (MEM_BYTES),
    .INIT_PATTERN(INIT_PATTERN)
  ) u_sram (
    .clk  (clk),
    .we   (fire && !err && cap_wr),
    .addr (cap_addr[AW-1:0]),
    .wdata(cap_wdata),
    .rdata(sram_rdata)
  );

  // Request FSM with registered response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      cap_addr      <= '0;
      cap_wdata     <= '0;
      cap_rd        <= 1'b0;
      cap_wr        <= 1'b0;
      cap_id        <= '0;
      mem_read_data <= '0;
      mem_ready     <= 1'b0;
      mem_error     <= 1'b0;
      mem_resp_id   <= '0;
      busy          <= 1'b0;
    end else begin
      mem_ready     <= 1'b0;
      mem_error     <= 1'b0;
      mem_read_data <= '0;
      unique case (state)
        IDLE: begin
          if (mem_request) begin
            cap_addr  <= mem_addr;
            cap_wdata <= mem_write_data;
            cap_rd    <= mem_read;
            cap_wr    <= mem_write;
            cap_id    <= mem_id;
            cnt       <= CNT_W'(LATENCY - 1);
            state     <= WAIT;
            busy      <= 1'b1;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state       <= RESP;
            mem_ready   <= 1'b1;
            mem_error   <= err;
            mem_resp_id <= cap_id;
            if (!err && cap_rd) begin
              mem_read_data <= sram_rdata;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (mem_request) begin
            state <= DRAIN;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        DRAIN: begin
          if (!mem_request) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
